dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Multi-cycle data-memory responder: the memory end of the cache<->memory load/store interface.
//  Accepts one request at a time and performs RV32 byte/half/word loads and stores on a word array.
//  Signals completion with a one-cycle data_ready pulse after a programmable latency.
//  Sits below the data cache; also usable directly behind the MEM stage for uncached tests.
// PARAMETERS
//  DEPTH      1024  number of 32-bit words; power of two
//  LATENCY    4     cycles from request acceptance to data_ready; legal range 1..15
//  INIT_FILE  ""    hex image loaded with $readmemh at elaboration when non-empty
// PORTS
//  clk         in   1   clock, rising edge
//  reset       in   1   asynchronous, active-high reset
//  req         in   1   request valid; sampled only in IDLE
//  writeEn     in   1   1 = store, 0 = load; sampled with req
//  addr        in   32  byte address; sampled with req
//  func3       in   3   RV32 load/store width code; sampled with req
//  storeVal    in   32  store data, LSB-aligned; sampled with req
//  loadVal     out  32  load result, extended; valid while data_ready=1, held until next load completes
//  data_ready  out  1   one-cycle completion pulse for both loads and stores
//  busy        out  1   1 from the cycle after acceptance until the data_ready cycle, inclusive
// BEHAVIOUR
//  - Reset values: data_ready=0, loadVal=0, busy=0, state=IDLE, counter=0. The array is NOT cleared.
//  - FSM: IDLE -> WAIT on req; WAIT -> DONE when counter==0; DONE -> IDLE unconditionally.
//  - Acceptance (IDLE & req): latch addr, func3, writeEn, storeVal; counter <= LATENCY-1; go to WAIT.
//  - WAIT: counter decrements each cycle. At 0, the array access is performed and the state goes to DONE.
//  - DONE: data_ready=1 for exactly one cycle. Timing: req accepted at cycle 0 -> data_ready at cycle LATENCY.
//  - req in WAIT or DONE is ignored, with no queueing. A req held high is re-accepted in the first IDLE
//    cycle after DONE, so back-to-back requests are spaced LATENCY+1 cycles apart.
//  - Word index = addr[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH.
//  - Loads: 000 LB and 100 LBU select the byte at addr[1:0]; 001 LH and 101 LHU select the half at addr[1].
//    LB/LH sign-extend; LBU/LHU zero-extend. 010 LW returns the full word.
//    The reserved codes 011, 110 and 111 behave as LW.
//  - Stores: 000 SB writes 1 byte lane, 001 SH writes 2 lanes, 010 SW writes all 4. Lanes are selected as
//    for loads. Unselected lanes are preserved. Other codes behave as SW.
//    loadVal is unchanged by stores.
//  - Misalignment, macro off: low address bits below the access width are ignored
//    (LW at 0x...2 reads the word at 0x...0).
//  - Reset asserted mid-operation aborts the access: no array write occurs and no data_ready is issued.
//    Reset release is synchronised by the parent.
// CONFIGURATION
//  DMEM_MISALIGN_ERR_EN defined:
//   - adds output port `err` (1 bit, reset value 0).
//   - A halfword with addr[0]=1, or a word with addr[1:0]!=0, still completes at the normal latency.
//   - On completion, err=1 for the data_ready cycle, no array write occurs, and loadVal=0.
//  DMEM_MISALIGN_ERR_EN undefined: no `err` port, and the ignore-low-bits behaviour above applies.
// STRUCTURE
//  - Package dmem_pkg: func3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the state encoding
//    (IDLE, WAIT, DONE, 2 bits).
//  - Sub-module dmem_lane_align (combinational):
//    - load: byte/half extraction plus sign/zero extension;
//    - store: lane merge of storeVal into the old word with 4-bit byte enables.
//  - Top level holds the FSM, latency counter, request latches and the word array.
// TESTING
//  1. Preload word 0x10 = 0x8081_F2F3. LB at 0x13 -> loadVal=0xFFFF_FF80 exactly 4 cycles after req;
//     LBU at 0x13 -> 0x0000_0080.
//  2. SH 0xABCD to 0x22 over word 0x1122_3344 -> a following LW at 0x20 returns 0xABCD_3344;
//     data_ready pulses once per request.
//  3. Hold req high for 3 LW requests -> data_ready at cycles 4, 9 and 14; busy low exactly at cycles 5 and 10.
//  4. Assert reset 2 cycles into an SW of 0xDEAD_BEEF to 0x40 -> no data_ready; word 0x40 keeps its old value;
//     outputs read 0.
//  5. Run with LATENCY=1: req at cycle 0 -> data_ready at cycle 1. An access at 4*DEPTH+8 hits word index 2.
//  6. With DMEM_MISALIGN_ERR_EN defined: SW at 0x41 -> err=1 together with data_ready, and word 0x40 unchanged.
//     LH at 0x42 -> err=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: RV32 load/store width
// codes and the responder FSM state encoding.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane alignment for the data-memory responder.
// Load side: extracts the addressed byte/half and sign- or zero-extends it.
// Store side: merges LSB-aligned store data into the old word under byte enables.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] old_word,
  input  logic [31:0] store_val,
  output logic [31:0] load_val,
  output logic [31:0] new_word
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [3:0]  byte_en_s;
  logic [31:0] wdata_s;

  // Pick the addressed byte and halfword out of the old word
  always_comb begin
    byte_s = 8'h00;
    case (byte_off)
      2'd0:    byte_s = old_word[7:0];
      2'd1:    byte_s = old_word[15:8];
      2'd2:    byte_s = old_word[23:16];
      default: byte_s = old_word[31:24];
    endcase
    half_s = byte_off[1] ? old_word[31:16] : old_word[15:0];
  end

  // Extend the selected field; reserved codes fall through to a full word
  always_comb begin
    load_val = old_word;
    case (func3)
      F3_B:    load_val = {{24{byte_s[7]}}, byte_s};
      F3_BU:   load_val = {24'h000000, byte_s};
      F3_H:    load_val = {{16{half_s[15]}}, half_s};
      F3_HU:   load_val = {16'h0000, half_s};
      default: load_val = old_word;
    endcase
  end

  // Replicate store data across lanes and merge only the enabled lanes
  always_comb begin
    byte_en_s = 4'b1111;
    wdata_s   = store_val;
    case (func3)
      F3_B: begin
        byte_en_s = 4'b0001 << byte_off;
        wdata_s   = {4{store_val[7:0]}};
      end
      F3_H: begin
        byte_en_s = byte_off[1] ? 4'b1100 : 4'b0011;
        wdata_s   = {2{store_val[15:0]}};
      end
      default: begin
        byte_en_s = 4'b1111;
        wdata_s   = store_val;
      end
    endcase
    new_word = old_word;
    for (int i = 0; i < 4; i++) begin
      new_word[8*i +: 8] = byte_en_s[i] ? wdata_s[8*i +: 8] : old_word[8*i +: 8];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder (memory side of the cache<->memory port).
// One request at a time; completion is a one-cycle data_ready pulse LATENCY
// cycles after acceptance. Optional feature macro: DMEM_MISALIGN_ERR_EN adds an
// `err` output that flags misaligned half/word accesses and suppresses them.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int    DEPTH     = 1024,
  parameter int    LATENCY   = 4,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        writeEn,
  input  logic [31:0] addr,
  input  logic [2:0]  func3,
  input  logic [31:0] storeVal,
  output logic [31:0] loadVal,
  output logic        data_ready,
`ifdef DMEM_MISALIGN_ERR_EN
  output logic        err,
`endif
  output logic        busy
);

  localparam int         AW     = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t        state_r;
  logic [3:0]    cnt_r;
  logic [AW+1:0] addr_r;
  logic [2:0]    f3_r;
  logic          we_r;
  logic [31:0]   sv_r;
  logic [31:0]   mem_r [DEPTH];

  logic          from_in_s;
  logic [AW+1:0] acc_addr_s;
  logic [AW-1:0] acc_idx_s;
  logic [2:0]    acc_f3_s;
  logic          acc_we_s;
  logic [31:0]   acc_sv_s;
  logic [31:0]   old_word_s;
  logic [31:0]   load_val_s;
  logic [31:0]   new_word_s;
  logic          do_access_s;
  logic          misalign_s;
  logic          unused_addr_s;

  // Upper address bits are intentionally dropped: addresses wrap modulo 4*DEPTH
  assign unused_addr_s = ^addr[31:AW+2];

  // With LATENCY=1 the access happens on the acceptance edge itself, before the
  // request latches are loaded, so the access operands come straight from the
  // inputs while IDLE and from the latches otherwise.
  assign from_in_s  = (state_r == IDLE);
  assign acc_addr_s = from_in_s ? addr[AW+1:0] : addr_r;
  assign acc_f3_s   = from_in_s ? func3 : f3_r;
  assign acc_we_s   = from_in_s ? writeEn : we_r;
  assign acc_sv_s   = from_in_s ? storeVal : sv_r;
  assign acc_idx_s  = acc_addr_s[AW+1:2];
  assign old_word_s = mem_r[acc_idx_s];

  // The access fires on the edge that moves the FSM into DONE, so data_ready
  // and loadVal are registered and appear together in the DONE cycle.
  assign do_access_s = ((state_r == IDLE) & req & (LAT_M1 == 4'd0)) |
                       ((state_r == WAIT) & (cnt_r == 4'd1));

`ifdef DMEM_MISALIGN_ERR_EN
  logic is_byte_s;
  logic is_half_s;
  assign is_byte_s  = acc_we_s ? (acc_f3_s == F3_B) : (acc_f3_s[1:0] == 2'b00);
  assign is_half_s  = acc_we_s ? (acc_f3_s == F3_H) : (acc_f3_s[1:0] == 2'b01);
  assign misalign_s = (is_half_s & acc_addr_s[0]) |
                      (~is_byte_s & ~is_half_s & (acc_addr_s[1:0] != 2'b00));
`else
  assign misalign_s = 1'b0;
`endif

  dmem_lane_align u_align (
    .func3     (acc_f3_s),
    .byte_off  (acc_addr_s[1:0]),
    .old_word  (old_word_s),
    .store_val (acc_sv_s),
    .load_val  (load_val_s),
    .new_word  (new_word_s)
  );

  // Word array write on store completion; reset aborts the pending access
  always_ff @(posedge clk) begin
    if (!reset && do_access_s && acc_we_s && !misalign_s) begin
      mem_r[acc_idx_s] <= new_word_s;
    end
  end

  // Request FSM, latency counter, request latches and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      addr_r     <= '0;
      f3_r       <= 3'b000;
      we_r       <= 1'b0;
      sv_r       <= 32'h0000_0000;
      loadVal    <= 32'h0000_0000;
      data_ready <= 1'b0;
      busy       <= 1'b0;
`ifdef DMEM_MISALIGN_ERR_EN
      err        <= 1'b0;
`endif
    end else begin
      data_ready <= 1'b0;
`ifdef DMEM_MISALIGN_ERR_EN
      err        <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
          if (req) begin
            addr_r  <= addr[AW+1:0];
            f3_r    <= func3;
            we_r    <= writeEn;
            sv_r    <= storeVal;
            cnt_r   <= LAT_M1;
            busy    <= 1'b1;
            state_r <= (LAT_M1 == 4'd0) ? DONE : WAIT;
          end else begin
            busy <= 1'b0;
          end
        end
        WAIT: begin
          busy <= 1'b1;
          if (cnt_r == 4'd1) begin
            cnt_r   <= 4'd0;
            state_r <= DONE;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          cnt_r   <= 4'd0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          cnt_r   <= 4'd0;
          state_r <= IDLE;
        end
      endcase
      if (do_access_s) begin
        data_ready <= 1'b1;
`ifdef DMEM_MISALIGN_ERR_EN
        err        <= misalign_s;
`endif
        if (misalign_s) begin
          loadVal <= 32'h0000_0000;
        end else if (!acc_we_s) begin
          loadVal <= load_val_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (LATENCY=4 main instance,
// LATENCY=1 small-depth instance for wrap and minimum-latency cases).
module tb_dmem_responder;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, writeEn;
  logic [31:0] addr, storeVal, loadVal;
  logic [2:0]  func3;
  logic        data_ready, busy;
  logic        req1, we1;
  logic [31:0] addr1, sv1, loadVal1;
  logic [2:0]  f31;
  logic        dr1, busy1;
`ifdef DMEM_MISALIGN_ERR_EN
  logic        err, err1, err_seen;
`endif

  int total = 0;
  int bad   = 0;
  int dr_cnt = 0;
  int lat, d0;
  logic [14:0] dr_v, bz_v;

  always #5 clk = ~clk;

  always @(negedge clk) if (data_ready === 1'b1) dr_cnt++;

  dmem_responder #(.DEPTH(1024), .LATENCY(4)) dut (
    .clk(clk), .reset(reset), .req(req), .writeEn(writeEn), .addr(addr),
    .func3(func3), .storeVal(storeVal), .loadVal(loadVal),
    .data_ready(data_ready),
`ifdef DMEM_MISALIGN_ERR_EN
    .err(err),
`endif
    .busy(busy)
  );

  dmem_responder #(.DEPTH(16), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req(req1), .writeEn(we1), .addr(addr1),
    .func3(f31), .storeVal(sv1), .loadVal(loadVal1),
    .data_ready(dr1),
`ifdef DMEM_MISALIGN_ERR_EN
    .err(err1),
`endif
    .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one request on the main instance; returns cycles until data_ready (20 = timeout)
  task automatic txn(input logic we, input logic [31:0] a, input logic [2:0] f3,
                     input logic [31:0] sv, output int l);
    @(negedge clk);
    req = 1'b1; writeEn = we; addr = a; func3 = f3; storeVal = sv;
    @(negedge clk);
    req = 1'b0;
    l = 1;
    while (data_ready !== 1'b1 && l < 20) begin
      @(negedge clk);
      l++;
    end
`ifdef DMEM_MISALIGN_ERR_EN
    err_seen = err;
`endif
  endtask

  task automatic txn1(input logic we, input logic [31:0] a, input logic [2:0] f3,
                      input logic [31:0] sv, output int l);
    @(negedge clk);
    req1 = 1'b1; we1 = we; addr1 = a; f31 = f3; sv1 = sv;
    @(negedge clk);
    req1 = 1'b0;
    l = 1;
    while (dr1 !== 1'b1 && l < 20) begin
      @(negedge clk);
      l++;
    end
  endtask

  task automatic ld(input string tag, input logic [31:0] a, input logic [2:0] f3,
                    input logic [31:0] exp);
    int l;
    txn(1'b0, a, f3, 32'h0000_0000, l);
    chk({tag, "_lat"}, l, 32'd4);
    chk(tag, loadVal, exp);
  endtask

  initial begin
    reset = 1'b1;
    req = 1'b0; writeEn = 1'b0; addr = 32'h0; func3 = 3'b000; storeVal = 32'h0;
    req1 = 1'b0; we1 = 1'b0; addr1 = 32'h0; f31 = 3'b000; sv1 = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_dr", data_ready, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_load", loadVal, 32'h0);
    chk("rst_dr1", dr1, 32'd0);
    reset = 1'b0;

    // 1: preload and sub-word loads
    txn(1'b1, 32'h10, F3_W, 32'h8081_F2F3, lat);
    chk("sw_lat", lat, 32'd4);
    ld("lb_13", 32'h13, F3_B, 32'hFFFF_FF80);
    ld("lbu_13", 32'h13, F3_BU, 32'h0000_0080);
    ld("lb_10", 32'h10, F3_B, 32'hFFFF_FFF3);
    ld("lbu_11", 32'h11, F3_BU, 32'h0000_00F2);
    ld("lb_12", 32'h12, F3_B, 32'hFFFF_FF81);
    ld("lh_12", 32'h12, F3_H, 32'hFFFF_8081);
    ld("lhu_10", 32'h10, F3_HU, 32'h0000_F2F3);
    ld("lrsv_011", 32'h10, 3'b011, 32'h8081_F2F3);
`ifndef DMEM_MISALIGN_ERR_EN
    ld("lw_mis12", 32'h12, F3_W, 32'h8081_F2F3);
`endif

    // 2: partial stores and pulse count
    @(negedge clk);
    d0 = dr_cnt;
    txn(1'b1, 32'h20, F3_W, 32'h1122_3344, lat);
    txn(1'b1, 32'h22, F3_H, 32'h0000_ABCD, lat);
    ld("lw_after_sh", 32'h20, F3_W, 32'hABCD_3344);
    txn(1'b1, 32'h21, F3_B, 32'hFFFF_FF55, lat);
    chk("load_kept_on_store", loadVal, 32'hABCD_3344);
    ld("lw_after_sb", 32'h20, F3_W, 32'hABCD_5544);
    txn(1'b1, 32'h24, 3'b100, 32'hCAFE_BABE, lat);
    ld("lw_store100", 32'h24, F3_W, 32'hCAFE_BABE);
    @(negedge clk);
    chk("dr_one_cycle", data_ready, 32'd0);
    chk("dr_count", dr_cnt - d0, 32'd7);

    // 3: req held high for three back-to-back loads
    @(negedge clk);
    req = 1'b1; writeEn = 1'b0; addr = 32'h20; func3 = F3_W;
    dr_v = '0; bz_v = '0;
    for (int c = 1; c < 15; c++) begin
      @(negedge clk);
      if (c == 11) req = 1'b0;
      dr_v[c] = data_ready;
      bz_v[c] = busy;
    end
    chk("b2b_dr", {17'd0, dr_v}, 32'h0000_4210);
    chk("b2b_busy", {17'd0, bz_v}, 32'h0000_7BDE);
    chk("b2b_load", loadVal, 32'hABCD_5544);

    // 4: reset mid-store
    txn(1'b1, 32'h40, F3_W, 32'h1234_5678, lat);
    @(negedge clk);
    req = 1'b1; writeEn = 1'b1; addr = 32'h40; func3 = F3_W; storeVal = 32'hDEAD_BEEF;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    d0 = dr_cnt;
    reset = 1'b1;
    #1;
    chk("abort_dr", data_ready, 32'd0);
    chk("abort_busy", busy, 32'd0);
    chk("abort_load", loadVal, 32'h0);
    repeat (6) @(negedge clk);
    chk("abort_no_pulse", dr_cnt - d0, 32'd0);
    reset = 1'b0;
    ld("lw_after_abort", 32'h40, F3_W, 32'h1234_5678);

    // 5: LATENCY=1 and address wrap on the 16-word instance
    txn1(1'b1, 32'd72, F3_W, 32'h0BAD_F00D, lat);
    chk("l1_sw_lat", lat, 32'd1);
    chk("l1_busy", busy1, 32'd1);
    txn1(1'b0, 32'h08, F3_W, 32'h0, lat);
    chk("l1_lw_lat", lat, 32'd1);
    chk("l1_wrap", loadVal1, 32'h0BAD_F00D);
    @(negedge clk);
    chk("l1_dr_drop", dr1, 32'd0);

`ifdef DMEM_MISALIGN_ERR_EN
    // 6: misalignment error reporting
    txn(1'b1, 32'h41, F3_W, 32'hFFFF_FFFF, lat);
    chk("mis_sw_lat", lat, 32'd4);
    chk("mis_sw_err", err_seen, 32'd1);
    ld("mis_sw_nowrite", 32'h40, F3_W, 32'h1234_5678);
    chk("lw_ok_err", err_seen, 32'd0);
    ld("lh_42", 32'h42, F3_H, 32'h0000_1234);
    chk("lh_42_err", err_seen, 32'd0);
    ld("mis_lw_zero", 32'h41, F3_W, 32'h0000_0000);
    chk("mis_lw_err", err_seen, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
